// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command scheduler:
// command encodings, sequencer state encoding and a counter helper.
package lcd_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        WRTBK = 3'd0,
        OP_UP = 3'd1,
        OP_DN = 3'd2,
        OP_LF = 3'd3,
        OP_RT = 3'd4,
        AVRGE = 3'd5,
        MRR_X = 3'd6,
        MRR_Y = 3'd7
    } lcd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_GAP       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FIN       = 3'd5
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Host/controller-facing signal bundle of the LCD command scheduler.
// The master side is the environment (host and LCD controller), the slave side is the scheduler.
interface lcd_cmd_seq_if;
    import lcd_pkg::*;

    logic [CMD_W-1:0] host_cmd;
    logic             host_valid;
    logic             host_ready;
    logic             start;
    logic [CMD_W-1:0] lcd_cmd;
    logic             lcd_cmd_valid;
    logic             lcd_busy;
    logic             lcd_done;
    logic             seq_busy;
    logic             seq_done;
    logic [7:0]       cmd_count;
    logic             err_ovf;
    logic             err_tmo;

    modport master (
        output host_cmd, host_valid, start, lcd_busy, lcd_done,
        input  host_ready, lcd_cmd, lcd_cmd_valid, seq_busy, seq_done,
               cmd_count, err_ovf, err_tmo
    );

    modport slave (
        input  host_cmd, host_valid, start, lcd_busy, lcd_done,
        output host_ready, lcd_cmd, lcd_cmd_valid, seq_busy, seq_done,
               cmd_count, err_ovf, err_tmo
    );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with flush; head entry is visible on dout whenever not empty.
// Flush has priority over any push or pop in the same cycle.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int W     = CMD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign full    = (r_count == CNT_FULL);
    assign empty   = (r_count == '0);
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;
    assign dout    = r_mem[r_rd_ptr];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command scheduler: queues host commands and, after start, issues them one at a
// time to the LCD controller until a write-back completes or times out.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    lcd_cmd_seq_if.slave bus
);

    // The wait counter starts at 0 on entry, so the limit is hit one count early.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;

    logic [CMD_W-1:0] w_fifo_dout;
    logic             w_full;
    logic             w_empty;
    logic             w_host_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_issue;
    logic             w_done_set;
    logic             w_tmo_set;
    logic             w_cnt_clr;
    logic             w_ovf_set;
    logic             w_busy_nxt;

    logic [CMD_W-1:0] r_lcd_cmd;
    logic             r_lcd_cmd_valid;
    logic             r_seq_busy;
    logic             r_seq_done;
    logic [7:0]       r_cmd_count;
    logic             r_err_ovf;
    logic             r_err_tmo;
    logic [7:0]       r_tmo_cnt;

    assign w_host_ready = !w_full && (r_state != ST_FIN);
    assign w_push       = bus.host_valid && w_host_ready;
    assign w_ovf_set    = bus.host_valid && w_full && (r_state != ST_FIN);

    assign bus.host_ready    = w_host_ready;
    assign bus.lcd_cmd       = r_lcd_cmd;
    assign bus.lcd_cmd_valid = r_lcd_cmd_valid;
    assign bus.seq_busy      = r_seq_busy;
    assign bus.seq_done      = r_seq_done;
    assign bus.cmd_count     = r_cmd_count;
    assign bus.err_ovf       = r_err_ovf;
    assign bus.err_tmo       = r_err_tmo;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (bus.host_cmd),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_done_set  = 1'b0;
        w_tmo_set   = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_WAIT_RDY;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (!w_empty && !bus.lcd_busy) begin
                    w_pop       = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_WAIT_RDY;
                end
            end
            ST_ISSUE: begin
                if (r_lcd_cmd == WRTBK) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_WAIT_RDY;
            end
            ST_WAIT_DONE: begin
                // Completion takes precedence over a timeout in the same cycle.
                if (bus.lcd_done) begin
                    w_done_set  = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_FIN;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_set   = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_FIN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, sticky flags, issue counter and write-back wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lcd_cmd       <= '0;
            r_lcd_cmd_valid <= 1'b0;
            r_seq_busy      <= 1'b0;
            r_seq_done      <= 1'b0;
            r_cmd_count     <= 8'd0;
            r_err_ovf       <= 1'b0;
            r_err_tmo       <= 1'b0;
            r_tmo_cnt       <= 8'd0;
        end else begin
            r_lcd_cmd_valid <= w_issue;
            r_seq_busy      <= w_busy_nxt;
            if (w_issue) begin
                r_lcd_cmd <= w_fifo_dout;
            end
            if (w_cnt_clr) begin
                r_cmd_count <= 8'd0;
            end else if (w_issue) begin
                r_cmd_count <= sat_inc8(r_cmd_count);
            end
            if (w_done_set) begin
                r_seq_done <= 1'b1;
            end
            if (w_tmo_set) begin
                r_err_tmo <= 1'b1;
            end
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end
            if (r_state == ST_WAIT_DONE) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end else begin
                r_tmo_cnt <= 8'd0;
            end
        end
    end

endmodule
